// File: rtl/urv_timebase.sv
// urv_timebase -- free-running cycle and time counters with a 40-bit timer
// compare register for the machine timer interrupt.
//
// The system clock is divided by N = g_clk_freq_hz / g_time_freq_hz (forced to
// 1 when the quotient is 0) to produce the architectural time rate. All outputs
// are registered, so the CSR read mux can use them directly.
//
// Optional feature macro: URV_TIMEBASE_CMP_EN
//   defined   : compare register and timer interrupt are built.
//   undefined : no compare storage, cmp_* inputs ignored, irq_timer_o tied 0.
//
// Ports:
//   clk_i         in   1  system clock (single domain)
//   rst_i         in   1  synchronous active-high reset
//   dbg_halt_i    in   1  freezes prescaler, time and cycles while high
//   cmp_wr_i      in   1  one-cycle compare write strobe
//   cmp_sel_i     in   1  0: write cmp[31:0], 1: write cmp[39:32]
//   cmp_data_i    in  32  compare write data ([7:0] only for the high half)
//   csr_cycles_o  out 40  cycle counter
//   csr_time_o    out 40  time counter
//   time_tick_o   out  1  high in the first cycle a new time value is visible
//   irq_timer_o   out  1  level timer interrupt (time >= cmp)

module urv_timebase #(
  parameter int unsigned g_clk_freq_hz  = 62500000,
  parameter int unsigned g_time_freq_hz = 1000000,
  parameter logic [39:0] g_cnt_init     = 40'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dbg_halt_i,
  input  logic        cmp_wr_i,
  input  logic        cmp_sel_i,
  input  logic [31:0] cmp_data_i,
  output logic [39:0] csr_cycles_o,
  output logic [39:0] csr_time_o,
  output logic        time_tick_o,
  output logic        irq_timer_o
);

  localparam int unsigned N_RAW = g_clk_freq_hz / g_time_freq_hz;
  localparam int unsigned N     = (N_RAW == 0) ? 1 : N_RAW;
  // A 1-bit prescaler is kept for N=1; it simply stays at 0.
  localparam int unsigned PW    = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] presc_q;
  logic [39:0]   cycles_q;
  logic [39:0]   time_q;
  logic          tick_q;
  logic          presc_last;

  assign presc_last = (presc_q == PW'(N - 1));

  // Halt takes priority over the terminal prescaler count: no increment and
  // no tick on a halted edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      cycles_q <= g_cnt_init;
      time_q   <= g_cnt_init;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= !dbg_halt_i && presc_last;
      if (!dbg_halt_i) begin
        cycles_q <= cycles_q + 40'd1;
        if (presc_last) begin
          presc_q <= '0;
          time_q  <= time_q + 40'd1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign csr_cycles_o = cycles_q;
  assign csr_time_o   = time_q;
  assign time_tick_o  = tick_q;

`ifdef URV_TIMEBASE_CMP_EN
  logic [39:0] cmp_q;
  logic        irq_q;

  // The irq compares registered time against registered cmp, so a write or a
  // tick on edge n is reflected in irq_timer_o after edge n+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q <= '1;
      irq_q <= 1'b0;
    end else begin
      irq_q <= (time_q >= cmp_q);
      if (cmp_wr_i) begin
        if (cmp_sel_i) begin
          cmp_q[39:32] <= cmp_data_i[7:0];
        end else begin
          cmp_q[31:0] <= cmp_data_i;
        end
      end
    end
  end

  assign irq_timer_o = irq_q;
`else
  logic unused_cmp;
  assign unused_cmp  = ^{cmp_wr_i, cmp_sel_i, cmp_data_i};
  assign irq_timer_o = 1'b0;
`endif

endmodule

// File: tb/tb_urv_timebase.sv
// Directed bench for urv_timebase. Three instances share clock and reset:
//   u_dut  : N=5, counters start at 0 (main scenarios)
//   u_wrap : N=5, counters start at 40'hFF_FFFF_FFFE (wrap-around)
//   u_n1   : quotient 0, so N is forced to 1 (tick always high)
// Expected values are pushed to exp_q when a step is driven and popped when
// the outputs are sampled 1 time unit after the clock edge.

module tb_urv_timebase;

`ifdef URV_TIMEBASE_CMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  localparam logic [39:0] WRAP_INIT = 40'hFF_FFFF_FFFE;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        dbg_halt_i;
  logic        cmp_wr_i;
  logic        cmp_sel_i;
  logic [31:0] cmp_data_i;

  logic [39:0] cyc, tim, w_cyc, w_tim, o_cyc, o_tim;
  logic        tick, irq, w_tick, w_irq, o_tick, o_irq;

  urv_timebase #(.g_clk_freq_hz(10), .g_time_freq_hz(2), .g_cnt_init(40'h0)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .dbg_halt_i(dbg_halt_i),
    .cmp_wr_i(cmp_wr_i), .cmp_sel_i(cmp_sel_i), .cmp_data_i(cmp_data_i),
    .csr_cycles_o(cyc), .csr_time_o(tim), .time_tick_o(tick), .irq_timer_o(irq)
  );

  urv_timebase #(.g_clk_freq_hz(10), .g_time_freq_hz(2), .g_cnt_init(WRAP_INIT)) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .dbg_halt_i(1'b0),
    .cmp_wr_i(1'b0), .cmp_sel_i(1'b0), .cmp_data_i(32'h0),
    .csr_cycles_o(w_cyc), .csr_time_o(w_tim), .time_tick_o(w_tick), .irq_timer_o(w_irq)
  );

  urv_timebase #(.g_clk_freq_hz(1), .g_time_freq_hz(2), .g_cnt_init(40'h0)) u_n1 (
    .clk_i(clk), .rst_i(rst_i), .dbg_halt_i(1'b0),
    .cmp_wr_i(1'b0), .cmp_sel_i(1'b0), .cmp_data_i(32'h0),
    .csr_cycles_o(o_cyc), .csr_time_o(o_tim), .time_tick_o(o_tick), .irq_timer_o(o_irq)
  );

  // scoreboard
  logic [39:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push(input logic [39:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [39:0] obs);
    logic [39:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmp(input logic wr, input logic sel, input logic [31:0] data);
    cmp_wr_i   = wr;
    cmp_sel_i  = sel;
    cmp_data_i = data;
  endtask

  // Leaves rst_i low just after an edge, so the next edge is edge 1.
  task automatic do_reset();
    rst_i      = 1'b1;
    dbg_halt_i = 1'b0;
    drive_cmp(1'b0, 1'b0, 32'h0);
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eff;
    logic halted;

    // ---------------- reset state + free-run + wrap + N=1 ----------------
    do_reset();
    push(40'h0);      chk("rst_cycles", cyc);
    push(40'h0);      chk("rst_time", tim);
    push(40'h0);      chk("rst_tick", {39'h0, tick});
    push(40'h0);      chk("rst_irq", {39'h0, irq});
    push(WRAP_INIT);  chk("rst_wrap_cycles", w_cyc);
    push(WRAP_INIT);  chk("rst_wrap_time", w_tim);
    push(40'h0);      chk("rst_n1_tick", {39'h0, o_tick});

    for (int k = 1; k <= 20; k++) begin
      push(40'(k));
      push(40'(k / 5));
      push({39'h0, (k % 5) == 0});
      push(40'h0);
      push(WRAP_INIT + 40'(k));
      push(WRAP_INIT + 40'(k / 5));
      push({39'h0, CMP_EN && (k >= 6) && (k <= 10)});
      push(40'h1);
      push(40'(k));
      push(40'h0);
      step();
      chk("free_cycles", cyc);
      chk("free_time", tim);
      chk("free_tick", {39'h0, tick});
      chk("free_irq", {39'h0, irq});
      chk("wrap_cycles", w_cyc);
      chk("wrap_time", w_tim);
      chk("wrap_irq", {39'h0, w_irq});
      chk("n1_tick", {39'h0, o_tick});
      chk("n1_time", o_tim);
      chk("n1_irq", {39'h0, o_irq});
    end

    // ---------------- compare: high=0, low=3, then low=100 ----------------
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      if (k == 1)       drive_cmp(1'b1, 1'b1, 32'h0);
      else if (k == 2)  drive_cmp(1'b1, 1'b0, 32'd3);
      else if (k == 21) drive_cmp(1'b1, 1'b0, 32'd100);
      else              drive_cmp(1'b0, 1'b0, 32'h0);
      push(40'(k));
      push(40'(k / 5));
      push({39'h0, CMP_EN && (k >= 16) && (k <= 21)});
      step();
      chk("cmp_cycles", cyc);
      chk("cmp_time", tim);
      chk("cmp_irq", {39'h0, irq});
    end
    drive_cmp(1'b0, 1'b0, 32'h0);

    // ---------------- halt: 7 cycles starting at prescaler=4 ----------------
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      halted     = (k >= 5) && (k <= 11);
      dbg_halt_i = halted;
      eff = (k < 5) ? k : ((k <= 11) ? 4 : k - 7);
      push(40'(eff));
      push(40'(eff / 5));
      push({39'h0, !halted && (eff % 5) == 0});
      step();
      chk("halt_cycles", cyc);
      chk("halt_time", tim);
      chk("halt_tick", {39'h0, tick});
    end
    dbg_halt_i = 1'b0;

    // ---------------- write on the tick edge, then reset with irq high ----------------
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      if (k == 1)       drive_cmp(1'b1, 1'b1, 32'h0);
      else if (k == 10) drive_cmp(1'b1, 1'b0, 32'd2);
      else              drive_cmp(1'b0, 1'b0, 32'h0);
      push(40'(k / 5));
      push({39'h0, CMP_EN && (k == 11)});
      step();
      chk("simul_time", tim);
      chk("simul_irq", {39'h0, irq});
    end

    rst_i = 1'b1;
    drive_cmp(1'b1, 1'b0, 32'h0);
    push(40'h0); push(40'h0); push(40'h0); push(40'h0);
    step();
    chk("midrst_cycles", cyc);
    chk("midrst_time", tim);
    chk("midrst_tick", {39'h0, tick});
    chk("midrst_irq", {39'h0, irq});
    rst_i = 1'b0;
    drive_cmp(1'b0, 1'b0, 32'h0);

    for (int k = 1; k <= 6; k++) begin
      push(40'(k));
      push(40'h0);
      step();
      chk("postrst_cycles", cyc);
      chk("postrst_irq", {39'h0, irq});
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover_expectations: observed %0d queued, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
